mips_hazard_unit: RTL
=====================

Name: mips_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It replaces the fixed, hazard-blind staging registers of the multicycle datapath.
- Keeps a shadow pipeline of destination/source register tags for EX, MEM and WB.
- Drives the ALU operand forwarding muxes, load-use stall, branch flush, and an optional ID-stage write-back bypass.
- Sits beside the datapath; touches no data, only tags and control.

Parameters:
- REG_ADDR_W, 5, register address width (register 0 is hard-wired zero, never a hazard).
- RF_WRITE_FIRST, 1, 1 = register file returns same-cycle write data on read; 0 = enable ID-stage WB bypass outputs.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_ADDR_W  ID source register A
- id_rt  in  REG_ADDR_W  ID source register B
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  REG_ADDR_W  ID destination (already muxed rt/rd)
- id_mem_rd  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- fwd_a_sel  out  2  EX operand A: 00 regfile/ID-EX, 10 EX/MEM result, 01 MEM/WB write data
- fwd_b_sel  out  2  EX operand B: same encoding
- id_fwd_a  out  1  ID-EX latch A takes WB write data (always 0 when RF_WRITE_FIRST=1)
- id_fwd_b  out  1  same for B
- stall_if_id  out  1  hold PC and IF/ID register
- flush_if_id  out  1  zero the IF/ID register
- flush_id_ex  out  1  load a bubble into the ID/EX register
- stall_cnt  out  CNT_W  load-use stall cycles (optional feature)
- flush_cnt  out  CNT_W  taken-branch flush events (optional feature)

Behaviour:
- Shadow stages EX, MEM, WB each hold: valid, wr_en, wr_addr, mem_rd, rs, rt (rs/rt held for EX only).
  - They advance every rising clk: MEM<-EX, WB<-MEM.
  - EX<-ID when id_valid, no stall and no flush; otherwise EX loads a bubble (valid=0).
- Reset (asynchronous, active-high): all shadow valid=0, all outputs 0, counters 0. Asserting reset mid-stall or mid-flush abandons the event; the first cycle after release shows no stall and no flush.
- Tag match: a source matches a stage when stage valid & wr_en & wr_addr!=0 & wr_addr==source.
- Forwarding (combinational from shadow EX rs/rt, zero latency):
  - 10 if MEM matches, else 01 if WB matches, else 00.
  - MEM has priority over WB.
  - fwd selects are 00 when shadow EX is a bubble.
- Load-use: stall_if_id=1 and flush_id_ex=1 when the shadow EX entry is a valid load and its wr_addr matches a used id_rs/id_rt (same match rules).
  - Exactly one stall cycle per hazard. The next cycle the load is in MEM, so no re-stall occurs.
  - By construction, a MEM match on a load never occurs in fwd selects; the bench asserts this.
- Branch: ex_branch_taken=1 gives flush_if_id=1 and flush_id_ex=1 for that cycle, with stall_if_id forced 0.
  - Taken branch has priority over a simultaneous load-use stall.
  - The ID instruction is discarded and enters EX as a bubble.
- ID bypass (RF_WRITE_FIRST=0 only): id_fwd_a/b=1 when WB matches a used ID source and no MEM or EX match exists for that source. Evaluated combinationally the same cycle.
- All flush/stall outputs are combinational from current inputs plus shadow state. No output depends on itself.

Optional Feature:
- Macro MIPS_HZD_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with stall_if_id=1.
  - flush_cnt increments on each cycle with ex_branch_taken=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> cycle the sub is in EX: fwd_a_sel=10, no stall.
- add $3 ; nop ; or $6,$3,$3 -> or in EX: fwd_a_sel=01, fwd_b_sel=01.
- lw $2,0($1) ; add $4,$2,$2 -> one cycle with stall_if_id=1 and flush_id_ex=1; next cycle add in EX with fwd_a_sel=fwd_b_sel=01; stall_cnt=1 (with MIPS_HZD_PERF_EN).
- Load-use hazard coincident with ex_branch_taken=1 -> stall_if_id=0, flush_if_id=1, flush_id_ex=1; flush_cnt=1.
- Writes to $0 followed by reads of $0 -> fwd selects 00, no stall, all cycles.
- RF_WRITE_FIRST=0, producer 3 ahead writing $7, consumer reads $7 in ID -> id_fwd_a=1 for that cycle; reset asserted mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: shadow tag pipeline, operand
// forwarding, load-use stall and branch flush. Optional perf counters under MIPS_HZD_PERF_EN.
module mips_hazard_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int RF_WRITE_FIRST = 1,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_mem_rd,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  id_fwd_a,
  output logic                  id_fwd_b,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic                  mem_rd;
    logic [REG_ADDR_W-1:0] wr_addr;
  } tag_t;

  tag_t                  ex_q, mem_q, wb_q;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q;
  logic                  rs_used, rt_used, load_use;

  function automatic logic hit(input tag_t s, input logic [REG_ADDR_W-1:0] src);
    return s.valid && s.wr_en && (s.wr_addr != '0) && (s.wr_addr == src);
  endfunction

  assign rs_used  = id_valid && id_uses_rs;
  assign rt_used  = id_valid && id_uses_rt;
  assign load_use = ex_q.mem_rd &&
                    ((rs_used && hit(ex_q, id_rs)) || (rt_used && hit(ex_q, id_rt)));

  always_comb begin
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    id_fwd_a    = 1'b0;
    id_fwd_b    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      if (ex_q.valid) begin
        if (hit(mem_q, ex_rs_q))      fwd_a_sel = 2'b10;
        else if (hit(wb_q, ex_rs_q))  fwd_a_sel = 2'b01;
        if (hit(mem_q, ex_rt_q))      fwd_b_sel = 2'b10;
        else if (hit(wb_q, ex_rt_q))  fwd_b_sel = 2'b01;
      end
      // A taken branch discards the ID instruction, so any load-use stall on it is moot.
      if (ex_branch_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      if (RF_WRITE_FIRST == 0) begin
        id_fwd_a = rs_used && hit(wb_q, id_rs) && !hit(mem_q, id_rs) && !hit(ex_q, id_rs);
        id_fwd_b = rt_used && hit(wb_q, id_rt) && !hit(mem_q, id_rt) && !hit(ex_q, id_rt);
      end
    end
  end

  // Unused sources are stored as $0 so they can never produce a forwarding match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (id_valid && !flush_id_ex) begin
        ex_q    <= '{valid: 1'b1, wr_en: id_wr_en, mem_rd: id_mem_rd, wr_addr: id_wr_addr};
        ex_rs_q <= id_uses_rs ? id_rs : '0;
        ex_rt_q <= id_uses_rt ? id_rt : '0;
      end else begin
        ex_q    <= '0;
        ex_rs_q <= '0;
        ex_rt_q <= '0;
      end
    end
  end

`ifdef MIPS_HZD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if_id && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ex_branch_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
